des_round_sequencer: RTL



---
 rtl/des_round_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/des_round_sequencer.sv
// des_round_sequencer: iterative DES engine, one Feistel round per clock
// through a single shared f-function, subkeys fetched by round index.
module des_round_sequencer #(
    parameter int ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_block,
    input  logic        in_decrypt,
    output logic [3:0]  round_idx,
    input  logic [47:0] subkey,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_block,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

    // One 256-bit word per S-box, row-major, entry 0 in the top nibble.
    localparam logic [0:7][255:0] SBOX = {
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175BA3E06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B
    };

    localparam int P_T [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25
    };

    // Source bit (1 = MSB) feeding output bit i of the initial permutation.
    function automatic int ip_src(input int i);
        int row;
        row = i / 8;
        return ((row < 4) ? 58 + 2 * row : 49 + 2 * row) - 8 * (i % 8);
    endfunction

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++)
            y[6'(63 - i)] = x[6'(64 - ip_src(i))];
        return y;
    endfunction

    function automatic logic [63:0] iip_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++)
            y[6'(64 - ip_src(i))] = x[6'(63 - i)];
        return y;
    endfunction

    function automatic logic [31:0] f_function(input logic [31:0] r,
                                               input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] y;
        logic [5:0]  six;
        logic [5:0]  idx;
        x = '0;
        s = '0;
        y = '0;
        for (int g = 0; g < 8; g++)
            for (int b = 0; b < 6; b++)
                x[6'(47 - 6 * g - b)] = r[5'(31 - ((4 * g + b + 31) % 32))];
        x = x ^ k;
        for (int g = 0; g < 8; g++) begin
            six = x[6'(47 - 6 * g) -: 6];
            idx = {six[5], six[0], six[4:1]};
            s[5'(31 - 4 * g) -: 4] = SBOX[3'(g)][8'(255 - 4 * int'(idx)) -: 4];
        end
        for (int i = 0; i < 32; i++)
            y[5'(31 - i)] = s[5'(32 - P_T[i])];
        return y;
    endfunction

    state_e      state_q, state_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        dec_q, dec_d;
    logic [63:0] res_q, res_d;
    logic [63:0] ip_blk;
    logic [63:0] fin_blk;
    logic [31:0] f_out;

    assign ip_blk  = ip_perm(in_block);
    assign f_out   = f_function(r_q, subkey);
    assign fin_blk = iip_perm({r_q, l_q});

    always_comb begin
        state_d   = state_q;
        l_d       = l_q;
        r_d       = r_q;
        cnt_d     = cnt_q;
        dec_d     = dec_q;
        res_d     = res_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        round_idx = '0;
        out_block = res_q;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    {l_d, r_d} = ip_blk;
                    dec_d      = in_decrypt;
                    cnt_d      = '0;
                    state_d    = ROUND;
                end
            end
            ROUND: begin
                busy      = 1'b1;
                round_idx = dec_q ? 4'(ROUNDS - 1) - cnt_q : cnt_q;
                l_d       = r_q;
                r_d       = l_q ^ f_out;
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == 4'(ROUNDS - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_block = fin_blk;
                if (out_ready) begin
                    res_d   = fin_blk;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            l_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            res_q   <= res_d;
        end
    end
endmodule
